// File: rtl/inner_prod_pkg.sv
// Shared definitions for the inner-product feeder and the inner-product stage.
// Element/result widths, vector length, FSM states and vector-select codes.
package inner_prod_pkg;

  localparam int VEC_LEN     = 8;
  localparam int DATA_W      = 8;
  localparam int IDX_W       = $clog2(VEC_LEN);
  localparam int CNT_W       = IDX_W + 1;                   // must hold VEC_LEN itself
  localparam int RES_W       = 2*DATA_W + $clog2(VEC_LEN);  // 19: 8*255*255 fits
  localparam int TIMEOUT_CYC = 4;
  localparam int WCNT_W      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // wr_sel encodings
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // One storage write: which vector, which element, what value.
  typedef struct packed {
    logic              sel;
    logic [IDX_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/inner_prod_vec_regfile.sv
// Two VEC_LEN x DATA_W element vectors (A and B).
// One synchronous write port, paired asynchronous read of A[idx]/B[idx],
// everything cleared by the asynchronous reset.
module inner_prod_vec_regfile
  import inner_prod_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  wr_req_t           wr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  // [vector][element][bit]
  logic [1:0][VEC_LEN-1:0][DATA_W-1:0] mem;

  // storage: whole array clears on reset, single element written per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem <= '0;
    else if (we) mem[wr.sel][wr.addr] <= wr.data;
  end

  assign rd_a = mem[SEL_A][rd_idx];
  assign rd_b = mem[SEL_B][rd_idx];

endmodule

// File: rtl/inner_prod_feeder.sv
// Sequencer feeding the 8-element inner-product stage.
// Loads A/B vectors through a write port, streams them pairwise with
// ip_valid high for VEC_LEN back-to-back cycles, then waits for the stage
// result, captures it and pulses done.
// Optional: define INNER_PROD_FEEDER_TIMEOUT_EN to bound the wait for the
// stage response and raise a sticky timeout flag.
module inner_prod_feeder
  import inner_prod_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic              ip_valid,
  output logic [DATA_W-1:0] ip_A,
  output logic [DATA_W-1:0] ip_B,
  input  logic              ip_valid_out,
  input  logic [RES_W-1:0]  ip_C,
  output logic [RES_W-1:0]  result,
  output logic              done
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              valid_nx, busy_nx, done_nx;
  logic [DATA_W-1:0] a_nx, b_nx;
  logic [RES_W-1:0]  res_nx;
  logic              we;
  wr_req_t           wr;
  logic [DATA_W-1:0] rd_a, rd_b;

`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  logic              timeout_nx;
`endif

  // Writes only land in IDLE, and a coincident start takes priority so the
  // vectors being streamed are exactly those present when start was seen.
  assign we = wr_en && (state == IDLE) && !start;
  assign wr = '{sel: wr_sel, addr: wr_addr, data: wr_data};

  inner_prod_vec_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wr     (wr),
    .rd_idx (cnt[IDX_W-1:0]),
    .rd_a   (rd_a),
    .rd_b   (rd_b)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and next values of every registered output
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    valid_nx = ip_valid;
    a_nx     = ip_A;
    b_nx     = ip_B;
    res_nx   = result;
    done_nx  = 1'b0;
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
    wcnt_nx    = wcnt;
    timeout_nx = timeout;
`endif
    unique case (state)
      IDLE: begin
        // cnt is 0 in IDLE, so the read ports already present element 0
        if (start) begin
          state_nx = STREAM;
          a_nx     = rd_a;
          b_nx     = rd_b;
          valid_nx = 1'b1;
          cnt_nx   = CNT_W'(1);
        end
      end
      STREAM: begin
        if (cnt == CNT_W'(VEC_LEN)) begin
          state_nx = WAIT;
          valid_nx = 1'b0;
          a_nx     = '0;
          b_nx     = '0;
          cnt_nx   = '0;
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
          wcnt_nx  = '0;
`endif
        end else begin
          a_nx   = rd_a;
          b_nx   = rd_b;
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (ip_valid_out) begin
          state_nx = IDLE;
          res_nx   = ip_C;
          done_nx  = 1'b1;
        end
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
        // give up after TIMEOUT_CYC sampled WAIT cycles without a response
        else if (wcnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          wcnt_nx = wcnt + WCNT_W'(1);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // registered outputs and element counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      busy     <= 1'b0;
      ip_valid <= 1'b0;
      ip_A     <= '0;
      ip_B     <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      busy     <= busy_nx;
      ip_valid <= valid_nx;
      ip_A     <= a_nx;
      ip_B     <= b_nx;
      result   <= res_nx;
      done     <= done_nx;
    end
  end

`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
  // wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      wcnt    <= wcnt_nx;
      timeout <= timeout_nx;
    end
  end
`endif

endmodule

// File: tb/tb_inner_prod_feeder.sv
// Directed bench for inner_prod_feeder with a behavioural inner-product stage.
module tb_inner_prod_feeder;
  import inner_prod_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0, wr_sel = 1'b0;
  logic [2:0]        wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              busy, ip_valid, done;
  logic [DATA_W-1:0] ip_A, ip_B;
  logic              ip_valid_out;
  logic [RES_W-1:0]  ip_C, result;
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
  logic              timeout;
`endif

  int checks = 0, errors = 0;
  bit stage_en = 1'b1;

  inner_prod_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy),
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .ip_valid(ip_valid), .ip_A(ip_A), .ip_B(ip_B), .ip_valid_out(ip_valid_out),
    .ip_C(ip_C), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  // stage model: accumulate 8 valid pairs, answer the cycle after the last one
  int          scnt;
  int unsigned acc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt = 0; acc = 0;
      ip_valid_out <= 1'b0; ip_C <= '0;
    end else begin
      ip_valid_out <= 1'b0;
      if (ip_valid && stage_en) begin
        acc += 32'(ip_A) * 32'(ip_B);
        scnt++;
        if (scnt == 8) begin
          ip_valid_out <= 1'b1;
          ip_C         <= acc[RES_W-1:0];
          acc = 0; scnt = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic s, input logic [2:0] ad, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = s; wr_addr = ad; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe a fixed window from the negedge after the start edge.
  int          vcnt, dcnt;
  logic [7:0]  seq [8];
  task automatic run_win(input int n, input bit inject);
    vcnt = 0; dcnt = 0;
    for (int i = 0; i < n; i++) begin
      if (ip_valid) begin
        if (vcnt < 8) seq[vcnt] = ip_A;
        vcnt++;
      end
      if (done) dcnt++;
      if (inject && i == 2) begin
        wr_en = 1'b1; wr_sel = SEL_A; wr_addr = 3'd0; wr_data = 8'd99; start = 1'b1;
      end
      if (inject && i == 4) begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   k;
    logic [7:0] orv;
    // reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ip_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ipA", ip_A, 0);
`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
    chk("rst_timeout", timeout, 0);
`endif

    // basic: A=1..8, B=1 -> 36
    for (int i = 0; i < 8; i++) begin
      wr(SEL_A, 3'(i), 8'(i + 1));
      wr(SEL_B, 3'(i), 8'd1);
    end
    start_pulse();
    chk("basic_busy", busy, 1);
    run_win(16, 1'b0);
    chk("basic_vcnt", vcnt, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("basic_seq%0d", i), seq[i], i + 1);
    chk("basic_dcnt", dcnt, 1);
    chk("basic_result", result, 36);
    chk("basic_idle", busy, 0);

    // maximum values -> 8*255*255
    for (int i = 0; i < 8; i++) begin
      wr(SEL_A, 3'(i), 8'd255);
      wr(SEL_B, 3'(i), 8'd255);
    end
    start_pulse();
    run_win(16, 1'b0);
    chk("max_result", result, 520200);

    // blocked write/start while busy
    for (int i = 0; i < 8; i++) begin
      wr(SEL_A, 3'(i), 8'(i + 1));
      wr(SEL_B, 3'(i), 8'd1);
    end
    start_pulse();
    run_win(16, 1'b1);
    chk("busy_vcnt", vcnt, 8);
    chk("busy_dcnt", dcnt, 1);
    chk("busy_result", result, 36);
    start_pulse();
    run_win(16, 1'b0);
    chk("busy_wr_dropped", result, 36);

    // start + write together in IDLE: start wins, write is lost
    start = 1'b1; wr_en = 1'b1; wr_sel = SEL_A; wr_addr = 3'd1; wr_data = 8'd50;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    run_win(16, 1'b0);
    chk("coinc_dcnt", dcnt, 1);
    chk("coinc_result", result, 36);

    // back-to-back: A=B=2 -> 32, restart in the done cycle
    for (int i = 0; i < 8; i++) begin
      wr(SEL_A, 3'(i), 8'd2);
      wr(SEL_B, 3'(i), 8'd2);
    end
    start_pulse();
    k = 0;
    while (!done && k < 30) begin @(negedge clk); k++; end
    chk("b2b_done1", done, 1);
    chk("b2b_result1", result, 32);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart", ip_valid, 1);
    chk("b2b_done_clr", done, 0);
    run_win(16, 1'b0);
    chk("b2b_vcnt", vcnt, 8);
    chk("b2b_dcnt", dcnt, 1);
    chk("b2b_result2", result, 32);

    // abort: reset during stream cycle 4
    start_pulse();
    repeat (3) @(negedge clk);
    chk("abort_pre_valid", ip_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", ip_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_pulse();
    run_win(16, 1'b0);
    orv = '0;
    for (int i = 0; i < 8; i++) orv |= seq[i];
    chk("abort_vcnt", vcnt, 8);
    chk("abort_mem_zero", orv, 0);
    chk("abort_dcnt", dcnt, 1);

`ifdef INNER_PROD_FEEDER_TIMEOUT_EN
    // no stage response -> timeout after 4 WAIT cycles
    for (int i = 0; i < 8; i++) wr(SEL_A, 3'(i), 8'd3);
    for (int i = 0; i < 8; i++) wr(SEL_B, 3'(i), 8'd3);
    stage_en = 1'b0;
    start_pulse();
    run_win(16, 1'b0);
    chk("to_flag", timeout, 1);
    chk("to_dcnt", dcnt, 0);
    chk("to_busy", busy, 0);
    chk("to_result", result, 0);
    stage_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inner_prod_feeder.md
Name: inner_prod_feeder

Overview:
Upstream sequencer for the 8-element inner-product stage. Software or a host FSM loads two 8-entry byte vectors (A, B) through a simple write port. On start, the block streams the vectors pairwise with valid held high for exactly VEC_LEN consecutive cycles. It then waits for the stage's valid_out, captures C, and signals done.

Parameters:
VEC_LEN, 8, elements per vector. Fixed at 8 to match the inner-product stage.
DATA_W, 8, element width.
RES_W, 19, result width; equals 2*DATA_W + clog2(VEC_LEN).
TIMEOUT_CYC, 4, maximum WAIT cycles before timeout. Used only with the optional feature.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  write strobe for vector storage.
wr_sel  in  1  0 writes vector A, 1 writes vector B.
wr_addr  in  3  element index, 0..7.
wr_data  in  DATA_W  element value.
start  in  1  single-cycle request to stream the stored vectors.
busy  out  1  high in STREAM and WAIT.
ip_valid  out  1  drives the inner-product stage valid_in.
ip_A  out  DATA_W  drives the stage A input.
ip_B  out  DATA_W  drives the stage B input.
ip_valid_out  in  1  stage valid_out.
ip_C  in  RES_W  stage result C.
result  out  RES_W  last captured inner product; holds until the next capture.
done  out  1  one-cycle pulse when result updates.
timeout  out  1  sticky error flag. Present only with the optional feature.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - busy, ip_valid, done and timeout are 0.
  - ip_A, ip_B, result and the element counter are 0.
  - All 16 storage bytes are 0.
- Reset mid-operation aborts streaming immediately. ip_valid drops asynchronously.
- All outputs are registered.
- State machine:
  - IDLE:
    - wr_en=1 writes mem[wr_sel][wr_addr] at the clock edge.
    - start=1 moves to STREAM. At that same edge, ip_A=A[0], ip_B=B[0], ip_valid=1, cnt=1.
    - If start and wr_en are high in the same cycle, start wins and the write is discarded.
  - STREAM:
    - Each edge with cnt<VEC_LEN loads ip_A=A[cnt], ip_B=B[cnt] and increments cnt.
    - At the edge where cnt==VEC_LEN, ip_valid=0, ip_A=ip_B=0, and the state moves to WAIT.
    - ip_valid is therefore high for exactly 8 consecutive cycles, with no gaps.
  - WAIT:
    - When ip_valid_out=1, result<=ip_C, done<=1 for one cycle, and the state returns to IDLE.
    - The stage is expected to respond one cycle after ip_valid falls.
- busy=1 exactly while state is STREAM or WAIT.
- Ignored inputs:
  - wr_en and start are ignored while busy. Stored vectors never change mid-stream.
  - ip_valid_out is ignored outside WAIT. result is unchanged in that case.
- Back-to-back operation: start may be asserted in the cycle done is high. The state is then IDLE, so STREAM begins at the next edge.
- Width: result is copied from ip_C with no arithmetic. The maximum legal value is 8*255*255 = 520200, which is below 2^19.

Optional Feature:
Macro: INNER_PROD_FEEDER_TIMEOUT_EN.
- Defined:
  - A wait counter runs in WAIT.
  - If ip_valid_out has not arrived after TIMEOUT_CYC cycles, timeout sets (sticky until rst) and the state returns to IDLE.
  - result is not updated and done is not pulsed.
- Undefined:
  - The timeout port and counter are absent.
  - WAIT waits indefinitely.

Decomposition:
- Shared package inner_prod_pkg holds:
  - DATA_W, VEC_LEN, RES_W;
  - the state enum (IDLE, STREAM, WAIT);
  - the wr_sel encodings SEL_A=0, SEL_B=1.
- The Inner_Prod stage also picks up DATA_W and RES_W from this package.
- One sub-module: inner_prod_vec_regfile.
  - 2x8xDATA_W storage with one synchronous write port, two asynchronous read ports indexed by cnt, and asynchronous clear on rst.

Test Plan:
- Reset check: rst pulse, then read outputs -> busy=0, ip_valid=0, done=0, result=0.
- Basic stream with stage model: load A=1..8, B=1 for all elements, pulse start.
  - ip_valid is high exactly 8 cycles with ip_A sequence 1..8.
  - The stage returns 36, then result=36 and done pulses for 1 cycle.
- Maximum values: A=B=255 for all elements -> result=520200, no truncation.
- Blocked inputs while busy:
  - Writing A[0]=99 while busy has no effect on the stored vector.
  - start while busy is ignored.
  - A coincident start+write in IDLE drops the write.
- Back-to-back runs: start asserted in the done cycle -> second stream starts at the next edge.
  - Second result is correct, for example A=B=2 for all elements gives 32.
- Abort and timeout:
  - Asserting rst in STREAM cycle 4 -> ip_valid=0 immediately, and storage reads back 0.
  - With INNER_PROD_FEEDER_TIMEOUT_EN and no stage response -> timeout=1 after 4 WAIT cycles, done stays 0.
